// File: rtl/eth_rx_pkg.sv
// Shared types for the receive frame buffer: write FSM states, RAM word, counter helper.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_word_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rx_frame_fifo_if.sv
// Byte-wide stream bundle (data, valid, ready, last, user) between MAC, buffer and consumer.
interface rx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_fifo_ram.sv
// Simple dual-port frame storage: one write port, one registered read port with enable.
// Read data appears one cycle after rd_en; no backpressure of its own.
module eth_fifo_ram
    import eth_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  fifo_word_t            wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output fifo_word_t            rd_dat
);

    fifo_word_t mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Only the output register is reset; the array keeps stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward RX frame buffer: frames become visible only once committed good; tvalid two cycles after tlast.
// Input cannot be stalled (overflowing/bad frames are dropped); output honours m_axis.tready.
module rx_frame_fifo
    import eth_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    rx_frame_fifo_if.slave         s_axis,
    rx_frame_fifo_if.master        m_axis,
    output logic [15:0]            good_count,
    output logic [15:0]            drop_count
);

    localparam int              PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   DEPTH = PW'(1) << ADDR_WIDTH;

    wr_state_t     state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
    logic          full, wr_en, commit, discard;
    logic          avail, rd_en, m_vld;
    fifo_word_t    wr_word, rd_word;

    assign full    = (wr_ptr - rd_ptr) == DEPTH;
    assign wr_word = '{last: s_axis.tlast, data: s_axis.tdata};

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        discard   = 1'b0;
        wr_en     = s_axis.tvalid && (state != WR_DROP) && !full;
        if (s_axis.tvalid) begin
            if (s_axis.tlast) begin
                state_nxt = WR_IDLE;
                if (wr_en && !s_axis.tuser) begin
                    commit = 1'b1;
                end else begin
                    discard = 1'b1;
                end
            end else begin
                // A first byte lost to a full buffer must poison the whole frame.
                case (state)
                    WR_IDLE:  state_nxt = full ? WR_DROP : WR_FRAME;
                    WR_FRAME: if (full) state_nxt = WR_DROP;
                    default:  state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WR_IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            good_count <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (discard) begin
                wr_ptr <= wr_commit;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                wr_commit  <= wr_ptr + PW'(1);
                good_count <= sat_inc(good_count);
            end
            if (discard) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    assign avail = rd_ptr != wr_commit;
    assign rd_en = avail && (!m_vld || m_axis.tready);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            m_vld  <= 1'b0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
            m_vld  <= 1'b1;
        end else if (m_axis.tready) begin
            m_vld  <= 1'b0;
        end
    end

    eth_fifo_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_dat  (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_dat  (rd_word)
    );

    assign m_axis.tdata  = rd_word.data;
    assign m_axis.tlast  = rd_word.last;
    assign m_axis.tvalid = m_vld;
    assign m_axis.tuser  = 1'b0;
    assign s_axis.tready = 1'b1;

endmodule

// File: doc/rx_frame_fifo.md
RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, giving a buffer depth of 2^ADDR_WIDTH bytes.
REQ-002 SHALL have port clk, input, 1 bit: 125 MHz MAC clock, the single clock of the block.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-004 SHALL have port s_axis_tdata, input, 8 bits: received byte from the MAC.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: byte valid; there is no tready, so the MAC cannot be stalled.
REQ-006 SHALL have port s_axis_tlast, input, 1 bit: last byte of the frame.
REQ-007 SHALL have port s_axis_tuser, input, 1 bit: bad-frame flag, sampled only on the tlast beat.
REQ-008 SHALL have port m_axis_tdata, output, 8 bits: buffered byte to the consumer.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: output byte valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: consumer accepts the byte.
REQ-011 SHALL have port m_axis_tlast, output, 1 bit: last byte of a committed frame.
REQ-012 SHALL have port good_count, output, 16 bits: number of committed frames, saturating.
REQ-013 SHALL have port drop_count, output, 16 bits: number of discarded frames, saturating.

Function
REQ-014 SHALL store each byte in RAM as a 9-bit word {last, data}; the write pointer, commit pointer and read pointer SHALL each be ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
REQ-015 SHALL treat the buffer as full when wr_ptr - rd_ptr == 2^ADDR_WIDTH, evaluated from registered pointers; space freed by a read in the same cycle SHALL NOT be usable until the next cycle.
REQ-016 SHALL implement a write FSM with states WR_IDLE, WR_FRAME and WR_DROP:
- WR_IDLE -> WR_FRAME on a valid byte without tlast.
- WR_FRAME -> WR_DROP on a valid byte while the buffer is full.
- Any state -> WR_IDLE on a tlast beat.
REQ-017 SHALL, in WR_IDLE or WR_FRAME with a valid byte and the buffer not full, write the byte at wr_ptr and increment wr_ptr.
REQ-018 SHALL commit the frame on a tlast beat only when all of these hold: tuser=0, state is not WR_DROP, and the beat itself was written.
- On commit: wr_commit <= wr_ptr+1 and good_count increments.
REQ-019 SHALL otherwise discard the frame on the tlast beat.
- On discard: wr_ptr <= wr_commit and drop_count increments exactly once per frame.
- A frame longer than the buffer is discarded the same way.
REQ-020 SHALL ignore bytes received in WR_DROP, apart from their tlast handling.
REQ-021 SHALL read only committed data, i.e. when rd_ptr != wr_commit.
REQ-022 SHALL issue a read when data is available and (!m_axis_tvalid || m_axis_tready).
- The RAM read register drives m_axis_tdata and m_axis_tlast directly.
- A read sets m_axis_tvalid; a handshake with no read clears it.
REQ-023 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 SHALL sustain one byte per cycle on the output when m_axis_tready=1.
REQ-025 SHALL assert m_axis_tvalid for the first byte of a frame two cycles after its tlast beat (tlast in cycle N, tvalid in cycle N+2) when the output is idle.
REQ-026 SHALL let both counters saturate at 0xFFFF without wrapping.

Reset
REQ-027 SHALL, while rst=1, clear all pointers, both counters, m_axis_tvalid, m_axis_tdata and m_axis_tlast to 0, and return the FSM to WR_IDLE.
REQ-028 SHALL discard any partial or committed-but-unread frame on reset; RAM contents are not cleared.
REQ-029 SHALL treat a frame already in progress when rst deasserts as if it started at its next byte.

Structure
REQ-030 SHALL keep the write-FSM state enum and the 9-bit {last,data} word type in shared package eth_rx_pkg.
REQ-031 SHALL place the storage in one sub-module, eth_fifo_ram: simple dual-port RAM, one write port and one registered read port with read enable.

Verification
REQ-032 SHALL cover a good frame: 64-byte frame 0x00..0x3F with tready=1 -> tvalid two cycles after tlast, 64 in-order beats, tlast on 0x3F, good_count=1.
REQ-033 SHALL cover a bad frame: 20-byte frame with tuser=1 on tlast, followed by a good 10-byte frame -> only the 10 bytes appear, drop_count=1, good_count=1.
REQ-034 SHALL cover an oversize frame: ADDR_WIDTH=6, 70-byte frame -> no output, drop_count=1; a following 60-byte frame is delivered intact.
REQ-035 SHALL cover a full buffer: ADDR_WIDTH=6, tready=0, 64-byte frame then a 10-byte frame -> first committed, second dropped; after draining, 64 bytes are delivered.
REQ-036 SHALL cover backpressure: tready pattern 1,0,1,0 during a 16-byte frame -> order preserved, tdata stable while stalled, exactly 16 handshakes.
REQ-037 SHALL cover reset mid-frame: rst pulsed after 10 bytes of a frame -> all outputs 0 next cycle, partial frame never emitted, counters 0.
